// File: rtl/bvh_traverse_ctrl.sv
// BVH traversal controller: walks one ray depth-first through node memory and emits hit leaves.
// Optional BVH_STATS_EN adds o_nodes_visited (saturating count of box tests for the current ray).
module bvh_traverse_ctrl #(
  parameter int unsigned NODE_AW     = 12,
  parameter int unsigned STACK_DEPTH = 8,
  parameter int unsigned ROOT_IDX    = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_ray_valid,
  output logic               o_ray_ready,
  input  logic [191:0]       i_ray,
  output logic               o_node_rd,
  output logic [NODE_AW-1:0] o_node_addr,
  input  logic               i_node_rvalid,
  input  logic [191:0]       i_node_bbox,
  input  logic               i_node_leaf,
  input  logic [NODE_AW-1:0] i_node_left,
  input  logic [NODE_AW-1:0] i_node_right,
  output logic [191:0]       o_rib_ray,
  output logic [191:0]       o_rib_bbox,
  input  logic               i_rib_intersects,
  output logic               o_leaf_valid,
  input  logic               i_leaf_ready,
  output logic [NODE_AW-1:0] o_leaf_tri_base,
  output logic [NODE_AW-1:0] o_leaf_tri_cnt,
  output logic               o_done,
  output logic               o_overflow
`ifdef BVH_STATS_EN
  ,
  output logic [15:0]        o_nodes_visited
`endif
);

  localparam int unsigned VEC_W = 192;
  localparam int unsigned SP_W  = $clog2(STACK_DEPTH) + 1;
  localparam int unsigned SI_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned SLOTS = 1 << SI_W;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_TEST, S_EMIT, S_POP, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [NODE_AW-1:0] cur_idx, cur_idx_nx;
  logic               node_leaf, node_leaf_nx;
  logic [NODE_AW-1:0] node_left, node_left_nx;
  logic [NODE_AW-1:0] node_right, node_right_nx;
  logic [SP_W-1:0]    sp, sp_nx;
  logic               push_en;
  logic [NODE_AW-1:0] stack [SLOTS];
  logic [NODE_AW-1:0] stack_top;
  logic               stack_empty, stack_full, accept;

  logic               ray_ready_nx, node_rd_nx, leaf_valid_nx, done_nx, overflow_nx;
  logic [NODE_AW-1:0] node_addr_nx, tri_base_nx, tri_cnt_nx;
  logic [VEC_W-1:0]   rib_ray_nx, rib_bbox_nx;

  assign accept      = i_ray_valid && o_ray_ready;
  assign stack_empty = (sp == '0);
  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign stack_top   = stack[SI_W'(sp - SP_W'(1))];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_FETCH;
      S_FETCH: state_nx = S_WAIT;
      S_WAIT:  if (i_node_rvalid) state_nx = S_TEST;
      S_TEST: begin
        if (!i_rib_intersects) state_nx = S_POP;
        else if (node_leaf)    state_nx = S_EMIT;
        else                   state_nx = S_FETCH;
      end
      S_EMIT:  if (o_leaf_valid && i_leaf_ready) state_nx = S_POP;
      S_POP:   state_nx = stack_empty ? S_DONE : S_FETCH;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    cur_idx_nx    = cur_idx;
    node_leaf_nx  = node_leaf;
    node_left_nx  = node_left;
    node_right_nx = node_right;
    sp_nx         = sp;
    push_en       = 1'b0;
    overflow_nx   = o_overflow;
    rib_ray_nx    = o_rib_ray;
    rib_bbox_nx   = o_rib_bbox;
    tri_base_nx   = o_leaf_tri_base;
    tri_cnt_nx    = o_leaf_tri_cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          rib_ray_nx  = i_ray;
          overflow_nx = 1'b0;
          cur_idx_nx  = NODE_AW'(ROOT_IDX);
        end
      end
      S_WAIT: begin
        if (i_node_rvalid) begin
          rib_bbox_nx   = i_node_bbox;
          node_leaf_nx  = i_node_leaf;
          node_left_nx  = i_node_left;
          node_right_nx = i_node_right;
        end
      end
      S_TEST: begin
        if (i_rib_intersects && node_leaf) begin
          tri_base_nx = node_left;
          tri_cnt_nx  = node_right;
        end else if (i_rib_intersects) begin
          // A full stack loses the right subtree but the left descent continues.
          if (stack_full) begin
            overflow_nx = 1'b1;
          end else begin
            push_en = 1'b1;
            sp_nx   = sp + SP_W'(1);
          end
          cur_idx_nx = node_left;
        end
      end
      S_POP: begin
        if (!stack_empty) begin
          cur_idx_nx = stack_top;
          sp_nx      = sp - SP_W'(1);
        end
      end
      default: ;
    endcase
    ray_ready_nx  = (state_nx == S_IDLE);
    node_rd_nx    = (state_nx == S_FETCH);
    leaf_valid_nx = (state_nx == S_EMIT);
    done_nx       = (state_nx == S_DONE);
    node_addr_nx  = (state_nx == S_FETCH) ? cur_idx_nx : o_node_addr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_ray_ready     <= 1'b1;
      o_node_rd       <= 1'b0;
      o_node_addr     <= '0;
      o_rib_ray       <= '0;
      o_rib_bbox      <= '0;
      o_leaf_valid    <= 1'b0;
      o_leaf_tri_base <= '0;
      o_leaf_tri_cnt  <= '0;
      o_done          <= 1'b0;
      o_overflow      <= 1'b0;
      cur_idx         <= NODE_AW'(ROOT_IDX);
      node_leaf       <= 1'b0;
      node_left       <= '0;
      node_right      <= '0;
      sp              <= '0;
    end else begin
      o_ray_ready     <= ray_ready_nx;
      o_node_rd       <= node_rd_nx;
      o_node_addr     <= node_addr_nx;
      o_rib_ray       <= rib_ray_nx;
      o_rib_bbox      <= rib_bbox_nx;
      o_leaf_valid    <= leaf_valid_nx;
      o_leaf_tri_base <= tri_base_nx;
      o_leaf_tri_cnt  <= tri_cnt_nx;
      o_done          <= done_nx;
      o_overflow      <= overflow_nx;
      cur_idx         <= cur_idx_nx;
      node_leaf       <= node_leaf_nx;
      node_left       <= node_left_nx;
      node_right      <= node_right_nx;
      sp              <= sp_nx;
    end
  end

  // Stack storage; entries above the pointer are don't-care, so no reset
  always_ff @(posedge clk) begin
    if (push_en) stack[SI_W'(sp)] <= node_right;
  end

`ifdef BVH_STATS_EN
  logic [15:0] visited_nx;

  always_comb begin
    visited_nx = o_nodes_visited;
    if (accept)                                          visited_nx = '0;
    else if (state == S_TEST && o_nodes_visited != 16'hFFFF) visited_nx = o_nodes_visited + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) o_nodes_visited <= '0;
    else       o_nodes_visited <= visited_nx;
  end
`endif

endmodule
